column_scan_sequencer: RTL and testbench

- Time-multiplexed column driver feeding the 5-way demultiplexer directly downstream: produces the 3-bit channel select and the WIDTH-bit data word for the active channel.
- Holds a double-buffered 5-entry frame. The host writes the back buffer; a swap commits it to the front buffer only at a frame boundary, so no torn frames reach the outputs.
- A prescaler sets dwell time per channel. A blanking window after each channel change suppresses ghosting on the driven display.

---
 rtl/scan_pkg.sv | 11 +
 rtl/tick_divider.sv | 17 +
 rtl/column_scan_sequencer.sv | 63 ++++++
 tb/tb_column_scan_sequencer.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/scan_pkg.sv
// scan_pkg: channel constants and index type shared by the column scan path
// (sequencer, demultiplexer wrapper, display top).
package scan_pkg;
   localparam int NUM_CH = 5;
   localparam int SEL_W = 3;
   typedef logic [SEL_W-1:0] ch_t;
   localparam ch_t LAST_CH = 3'd4;
   function automatic ch_t next_ch(input ch_t c);
      return (c == LAST_CH) ? '0 : c + ch_t'(1);
   endfunction
endpackage

// File: rtl/tick_divider.sv
// tick_divider: prescaler producing a one-cycle tick every DIV enabled cycles;
// the count freezes while enable is low.
module tick_divider #(
   parameter int DIV = 50000
) (
   input  logic clk,
   input  logic rst,
   input  logic enable,
   output logic tick
);
   localparam int PW = $clog2(DIV);
   logic [PW-1:0] pcnt;
   assign tick = enable && pcnt == PW'(DIV - 1);
   always_ff @(posedge clk or posedge rst)
      if (rst) pcnt <= '0;
      else if (enable) pcnt <= tick ? '0 : pcnt + 1'b1;
endmodule

// File: rtl/column_scan_sequencer.sv
// column_scan_sequencer: time-multiplexed column driver with a double-buffered
// 5-entry frame, per-channel dwell, post-switch blanking and tear-free swaps.
module column_scan_sequencer
   import scan_pkg::*;
#(
   parameter int WIDTH = 7,
   parameter int DIV = 50000,
   parameter int BLANK = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   input  logic             wr_en,
   input  logic [2:0]       wr_addr,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             swap_req,
   output logic             swap_pending,
   output logic             swap_done,
   output logic [SEL_W-1:0] sel,
   output logic [WIDTH-1:0] data_out,
   output logic             frame_start
);
   localparam int BW = (BLANK > 0) ? $clog2(BLANK + 1) : 1;
   logic tick, wrap, commit;
   logic [BW-1:0] bcnt;
   logic [WIDTH-1:0] front [NUM_CH];
   logic [WIDTH-1:0] back [NUM_CH];

   tick_divider #(.DIV(DIV)) u_div (
      .clk(clk),
      .rst(rst),
      .enable(enable),
      .tick(tick)
   );

   assign wrap = tick && sel == LAST_CH;
   assign commit = wrap && swap_pending;

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         sel <= '0;
         bcnt <= '0;
         data_out <= '0;
         frame_start <= 1'b0;
         swap_pending <= 1'b0;
         swap_done <= 1'b0;
         for (int i = 0; i < NUM_CH; i++) begin
            front[i] <= '0;
            back[i] <= '0;
         end
      end else begin
         sel <= tick ? next_ch(sel) : sel;
         frame_start <= wrap;
         swap_done <= commit;
         // a request landing on the commit edge is absorbed by that commit
         swap_pending <= !commit && (swap_pending || swap_req);
         bcnt <= tick ? BW'(BLANK) : (enable && bcnt != '0) ? bcnt - 1'b1 : bcnt;
         data_out <= (bcnt != '0 || !enable) ? '0 : front[sel];
         if (commit)
            for (int i = 0; i < NUM_CH; i++) front[i] <= back[i];
         if (wr_en && wr_addr <= LAST_CH) back[wr_addr] <= wr_data;
      end
endmodule

// File: tb/tb_column_scan_sequencer.sv
// tb_column_scan_sequencer: table vectors, directed corner sequences and random
// traffic against an arithmetic reference model of the scan sequencer.
module tb_column_scan_sequencer;
   localparam int WIDTH = 7;
   localparam int DIV = 4;
   localparam int BLANK = 1;

   logic clk = 0, rst = 1, enable = 0, wr_en = 0, swap_req = 0;
   logic [2:0] wr_addr = '0;
   logic [WIDTH-1:0] wr_data = '0;
   logic swap_pending, swap_done, frame_start;
   logic [2:0] sel;
   logic [WIDTH-1:0] data_out;

   column_scan_sequencer #(.WIDTH(WIDTH), .DIV(DIV), .BLANK(BLANK)) dut (
      .clk(clk), .rst(rst), .enable(enable), .wr_en(wr_en), .wr_addr(wr_addr),
      .wr_data(wr_data), .swap_req(swap_req), .swap_pending(swap_pending),
      .swap_done(swap_done), .sel(sel), .data_out(data_out), .frame_start(frame_start)
   );

   always #5 clk = ~clk;

   int n_chk = 0, n_err = 0;
   int m_n;
   int m_front [5];
   int m_back [5];
   bit m_pend;
   int e_sel, e_data;
   bit e_frame, e_done;

   typedef struct {
      bit en;
      int sel;
      bit fs;
      int d;
   } vec_t;
   vec_t tbl [22];

   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_n = 0;
      m_pend = 0;
      e_sel = 0; e_data = 0; e_frame = 0; e_done = 0;
      for (int i = 0; i < 5; i++) begin
         m_front[i] = 0;
         m_back[i] = 0;
      end
   endtask

   // Enabled-cycle count n gives dwell phase n%DIV and channel (n/DIV)%5;
   // the cycles right after each channel switch (phase < BLANK) are blanked.
   task automatic model_step(input bit en, input bit we, input int wa, input int wd, input bit sr);
      int pc, s;
      bit tk, wr, blank;
      pc = m_n % DIV;
      s = (m_n / DIV) % 5;
      tk = en && pc == DIV - 1;
      wr = tk && s == 4;
      blank = m_n >= DIV && pc < BLANK;
      e_data = (blank || !en) ? 0 : m_front[s];
      e_frame = wr;
      e_done = wr && m_pend;
      if (wr && m_pend) begin
         for (int i = 0; i < 5; i++) m_front[i] = m_back[i];
         m_pend = 0;
      end else if (sr) m_pend = 1;
      if (we && wa <= 4) m_back[wa] = wd;
      if (en) m_n++;
      e_sel = (m_n / DIV) % 5;
   endtask

   task automatic step(input bit en, input bit we, input int wa, input int wd, input bit sr);
      enable = en; wr_en = we; wr_addr = 3'(wa); wr_data = WIDTH'(wd); swap_req = sr;
      @(posedge clk);
      model_step(en, we, wa, wd, sr);
      #1;
      chk("sel", sel, e_sel);
      chk("data_out", data_out, e_data);
      chk("frame_start", frame_start, e_frame);
      chk("swap_done", swap_done, e_done);
      chk("swap_pending", swap_pending, m_pend);
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0);
   endtask

   task automatic wait_model(input int s, input int pc);
      bit hit = 0;
      for (int i = 0; i < 60 && !hit; i++) begin
         step(1, 0, 0, 0, 0);
         hit = ((m_n / DIV) % 5 == s) && (m_n % DIV == pc);
      end
      if (!hit) chk("wait_phase_timeout", 0, 1);
   endtask

   task automatic wait_done();
      bit hit = 0;
      for (int i = 0; i < 60 && !hit; i++) begin
         step(1, 0, 0, 0, 0);
         hit = e_done;
      end
      chk("swap_done_seen", swap_done, 1);
   endtask

   initial begin
      tbl = '{'{1,0,0,0}, '{1,0,0,0}, '{1,0,0,0}, '{1,1,0,0}, '{1,1,0,0}, '{1,1,0,0},
              '{1,1,0,0}, '{1,2,0,0}, '{1,2,0,0}, '{1,2,0,0}, '{1,2,0,0}, '{1,3,0,0},
              '{1,3,0,0}, '{1,3,0,0}, '{1,3,0,0}, '{1,4,0,0}, '{1,4,0,0}, '{1,4,0,0},
              '{1,4,0,0}, '{1,0,1,0}, '{1,0,0,0}, '{1,0,0,0}};
      model_reset();
      #3;
      chk("rst_sel", sel, 0);
      chk("rst_data", data_out, 0);
      chk("rst_pending", swap_pending, 0);
      chk("rst_done", swap_done, 0);
      chk("rst_frame", frame_start, 0);
      @(negedge clk);
      rst = 0;

      foreach (tbl[k]) begin
         step(tbl[k].en, 0, 0, 0, 0);
         chk("tbl_sel", sel, tbl[k].sel);
         chk("tbl_frame", frame_start, tbl[k].fs);
         chk("tbl_data", data_out, tbl[k].d);
      end

      for (int i = 0; i < 5; i++) step(1, 1, i, 1 << i, 0);
      step(1, 0, 0, 0, 1);
      chk("pending_after_req", swap_pending, 1);
      wait_done();
      wait_model(0, 2);
      chk("ch0_word", data_out, 7'h01);
      wait_model(1, 2);
      chk("ch1_word", data_out, 7'h02);
      wait_model(4, 2);
      chk("ch4_word", data_out, 7'h10);

      for (int a = 5; a < 8; a++) step(1, 1, a, 7'h7f, 0);
      step(1, 0, 0, 0, 1);
      wait_done();
      wait_model(3, 2);
      chk("oob_write_ignored", data_out, 7'h08);

      step(1, 0, 0, 0, 1);
      wait_model(4, 3);
      step(1, 1, 2, 7'h55, 1);
      chk("req_consumed_by_commit", swap_pending, 0);
      wait_model(2, 2);
      chk("commit_write_deferred", data_out, 7'h04);
      step(1, 0, 0, 0, 1);
      wait_done();
      wait_model(2, 2);
      chk("second_swap_word", data_out, 7'h55);

      wait_model(3, 2);
      for (int i = 0; i < 10; i++) step(0, 0, 0, 0, 0);
      chk("hold_sel", sel, 3);
      chk("hold_data", data_out, 0);
      step(1, 0, 0, 0, 0);
      chk("resume_sel_1", sel, 3);
      step(1, 0, 0, 0, 0);
      chk("resume_sel_2", sel, 4);

      for (int i = 0; i < 400; i++)
         step($urandom_range(0, 9) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 7),
              $urandom_range(0, 127), $urandom_range(0, 7) == 0);

      wait_model(0, 1);
      for (int i = 0; i < 5; i++) step(1, 1, i, 7'h40 + i, 0);
      step(1, 0, 0, 0, 1);
      wait_model(2, 1);
      chk("pending_before_rst", swap_pending, 1);
      #2 rst = 1;
      #1;
      chk("async_rst_sel", sel, 0);
      chk("async_rst_data", data_out, 0);
      chk("async_rst_pending", swap_pending, 0);
      chk("async_rst_done", swap_done, 0);
      @(negedge clk);
      rst = 0;
      model_reset();
      idle(45);
      chk("post_rst_data", data_out, 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
